// File: rtl/swap_sequencer.sv
// Sequencer around the shared 4:1 bus mux: owns registers A, B and T, loads A/B
// from external data while idle and swaps A<->B through T over three bus transfers.
module swap_sequencer #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] bus_in,
  input  logic         ld_a,
  input  logic         ld_b,
  input  logic         swap,
  output logic [1:0]   sel,
  output logic [N-1:0] a_q,
  output logic [N-1:0] b_q,
  output logic [N-1:0] t_q,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    XFER_T = 3'd1,
    XFER_A = 3'd2,
    XFER_B = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] a_d, b_d, t_d;

  // bus_in is the mux output for the current sel, so each transfer state simply
  // captures the bus into its destination register.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    t_d     = t_q;
    case (state_q)
      IDLE: begin
        if (swap) begin
          state_d = XFER_T;
        end else begin
          if (ld_a) a_d = bus_in;
          if (ld_b) b_d = bus_in;
        end
      end
      XFER_T: begin
        t_d     = bus_in;
        state_d = XFER_A;
      end
      XFER_A: begin
        a_d     = bus_in;
        state_d = XFER_B;
      end
      XFER_B: begin
        b_d     = bus_in;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      t_q     <= t_d;
    end
  end

  // Moore decode: outputs depend on the state register only.
  always_comb begin
    sel  = 2'b00;
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      XFER_T: begin sel = 2'b01; busy = 1'b1; end
      XFER_A: begin sel = 2'b10; busy = 1'b1; end
      XFER_B: begin sel = 2'b11; busy = 1'b1; end
      DONE:   begin sel = 2'b00; busy = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

endmodule
